// File: rtl/aritmetica_secuenciador.sv
// aritmetica_secuenciador
//   Operand sequencer and result collector around the combinational
//   Aritmetica datapath. One operand triple is accepted at a time, held
//   stable on the operand outputs for LAT cycles, and then Valores is
//   sampled into a small result FIFO that drains over a valid/ready stream.
//
// Parameters
//   N     operand/result width
//   LAT   settling cycles before Valores is sampled (1..15)
//   DEPTH result FIFO entries (power of two, >= 2)
//
// Ports
//   CLK, RESET                     clock (rising), async active-low reset
//   in_valid/in_ready              operand triple handshake
//   in_const/in_mult/in_entr       operand triple
//   Constantes_G/Multip_G/Entrada_G registered operands to Aritmetica
//   Valores                        result from Aritmetica
//   out_valid/out_ready/out_data   result stream (FIFO head)
//   busy                           triple in flight
//
// Optional build macro ARIT_SEQ_CONTADOR_EN adds:
//   res_count [15:0]  wrapping count of FIFO pushes
//   drop_flag         sticky: in_valid seen in IDLE while FIFO full
module aritmetica_secuenciador #(
  parameter int N     = 24,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_const,
  input  logic [N-1:0] in_mult,
  input  logic [N-1:0] in_entr,
  output logic [N-1:0] Constantes_G,
  output logic [N-1:0] Multip_G,
  output logic [N-1:0] Entrada_G,
  input  logic [N-1:0] Valores,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
`ifdef ARIT_SEQ_CONTADOR_EN
  ,
  output logic [15:0]  res_count,
  output logic         drop_flag
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         r_state, w_state_nxt;
  logic [3:0]     r_wcnt;
  logic [N-1:0]   r_const, r_mult, r_entr;
  logic [N-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_last;

  logic           w_room, w_accept, w_push, w_pop;

  // Accept gating looks only at the registered count; a pop in the same
  // cycle does not open a slot early.
  assign w_room    = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  assign Constantes_G = r_const;
  assign Multip_G     = r_mult;
  assign Entrada_G    = r_entr;

  // When empty the head slot may hold stale data, so show the last value
  // that actually left the FIFO instead.
  assign out_data = out_valid ? r_mem[r_rd_ptr] : r_last;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_push      = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = RESET && w_room;
        if (in_valid && RESET && w_room) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_wcnt == 4'd0) begin
          w_push      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_const <= '0;
      r_mult  <= '0;
      r_entr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_const <= in_const;
        r_mult  <= in_mult;
        r_entr  <= in_entr;
        r_wcnt  <= 4'(LAT - 1);
      end else if (r_state == S_WAIT && r_wcnt != 4'd0) begin
        r_wcnt <= r_wcnt - 4'd1;
      end
    end
  end

  // Result FIFO. Accept gating guarantees room for every push.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= Valores;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ARIT_SEQ_CONTADOR_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      res_count <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (w_push) res_count <= res_count + 16'd1;
      if (r_state == S_IDLE && in_valid && !w_room) drop_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/aritmetica_secuenciador.md
Name: aritmetica_secuenciador

Overview:
- Operand sequencer and result collector wrapped around the combinational Aritmetica datapath.
- Accepts operand triples over a valid/ready input stream and drives Constantes_G, Multip_G and Entrada_G.
- Holds the operands stable for a programmable settling time, samples Valores and queues it in a result FIFO.
- Results leave through a valid/ready output stream; this is the hardware replacement for file-driven stimulus/capture.

Parameters:
- N, 24: operand and result width in bits.
- LAT, 2: settling cycles before Valores is sampled; legal range 1..15.
- DEPTH, 4: result FIFO entries; power of two, at least 2.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous active-low reset.
- in_valid  input  1  operand triple valid.
- in_ready  output  1  sequencer can accept a triple.
- in_const  input  N  constant operand.
- in_mult  input  N  multiplier operand.
- in_entr  input  N  input sample operand.
- Constantes_G  output  N  registered operand to Aritmetica.
- Multip_G  output  N  registered operand to Aritmetica.
- Entrada_G  output  N  registered operand to Aritmetica.
- Valores  input  N  result returned by Aritmetica.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  N  FIFO head data.
- busy  output  1  a triple is in flight (state WAIT).

Behaviour:
- Reset (RESET=0, asynchronous):
  - State goes to IDLE.
  - Operand outputs, out_data and the FIFO pointers and count all clear to 0.
  - in_ready=0 while RESET is asserted; out_valid=0; busy=0.
  - Reset mid-operation discards the in-flight triple and all queued results.
- State machine:
  - IDLE: in_ready = (fifo_count < DEPTH), registered count, no same-cycle pop look-ahead. On in_valid && in_ready at edge T, register the three operands onto Constantes_G/Multip_G/Entrada_G, load wait counter with LAT-1, go to WAIT.
  - WAIT: in_ready=0, busy=1, operand outputs held stable. Counter decrements each edge. At the edge where counter==0 (edge T+LAT), push Valores into the FIFO and return to IDLE.
- Timing and throughput:
  - Accept-to-capture is LAT cycles; out_valid rises after edge T+LAT when the FIFO was empty.
  - Earliest next accept is edge T+LAT+1, so throughput is one triple per LAT+1 cycles.
- Overflow rule:
  - Accept is gated on count<DEPTH, so the push can never overflow.
  - A pop during WAIT never blocks the push.
- FIFO:
  - Pop on out_valid && out_ready; out_data = head, valid whenever count>0.
  - Simultaneous push and pop keeps count unchanged with both pointers advancing.
  - Pointers wrap modulo DEPTH.
  - When empty, out_valid=0 and out_data holds its last value (0 after reset).
- Width rules: Valores is captured as-is, N bits, no extension or truncation.
- Operand outputs retain their last values in IDLE.

Optional Feature:
- Macro ARIT_SEQ_CONTADOR_EN.
- When defined, add output res_count [15:0]:
  - Increments on every FIFO push, wraps 0xFFFF to 0x0000.
  - Reset to 0.
- Add output drop_flag:
  - Sticky; set when in_valid=1 while in_ready=0 in IDLE because the FIFO is full.
  - Cleared only by reset.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Bench stub uses Valores = Entrada_G + 1, with LAT=2.
- Single triple: send (0x000010, 0x000002, 0x000005) with out_ready=1 -> operands appear on the next edge, out_valid one cycle after edge T+2, out_data=0x000006.
- Back-to-back: hold in_valid=1 for 5 triples with Entrada_G 1..5 -> accepts exactly 3 cycles apart; outputs 2,3,4,5,6 in order.
- Full FIFO: out_ready=0, push DEPTH=4 triples -> in_ready stays 0 with in_valid=1 on the 5th; raising out_ready for one cycle releases one slot, the 5th triple is accepted, no data is lost.
- Simultaneous push/pop: count=2, out_ready=1 at the capture edge -> count stays 2 and order is preserved across the pointer wrap.
- Reset mid-WAIT: assert RESET one cycle after accept with 2 results queued -> out_valid=0 and busy=0 immediately; after release in_ready=1 and the first new result is the first output.
- With ARIT_SEQ_CONTADOR_EN: 70000 pushes -> res_count=4464 (70000 mod 65536); pushing in_valid while full sets drop_flag=1.
